// File: rtl/queue_btn_ctrl_if.sv
// Button/queue command bus for queue_btn_ctrl.
// slave: the controller (takes buttons and size, drives strobes and debug levels).
// master: the board/queue side.
interface queue_btn_ctrl_if;
    localparam int unsigned SIZE_W = 5;

    logic              btn_push;
    logic              btn_pop;
    logic [SIZE_W-1:0] size;
    logic              push;
    logic              pop;
    logic              rej;
    logic [1:0]        btn_lvl;

    modport master (
        output btn_push, btn_pop, size,
        input  push, pop, rej, btn_lvl
    );

    modport slave (
        input  btn_push, btn_pop, size,
        output push, pop, rej, btn_lvl
    );
endinterface

// File: rtl/queue_btn_ctrl.sv
// queue_btn_ctrl: turns two raw buttons into single-cycle push/pop strobes for a
// 16-entry occupancy queue. Sync (2 FF) -> debounce -> rising-edge detect ->
// size gating -> push/pop arbitration with a one-deep pending pop.
// Optional macro AUTOREPEAT_EN: held buttons re-request after REPEAT_DLY cycles,
// then every REPEAT_PER cycles (requires REPEAT_PER <= REPEAT_DLY <= 255).
// Button index 0 = push, 1 = pop throughout.
module queue_btn_ctrl #(
    parameter int unsigned DEB_CNT    = 16,
    parameter int unsigned MAXSIZE    = 16
`ifdef AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DLY = 20,
    parameter int unsigned REPEAT_PER = 10
`endif
) (
    input  logic            clk,
    input  logic            rst,
    queue_btn_ctrl_if.slave bus
);

    localparam int unsigned NB = 2;
    localparam int unsigned CW = 8;

    logic [NB-1:0]         sync1;
    logic [NB-1:0]         sync2;
    logic [NB-1:0]         deb;
    logic [NB-1:0]         deb_q;
    logic [NB-1:0][CW-1:0] cnt;
    logic [NB-1:0]         req;
    logic [NB-1:0]         ev;

    logic push_q, pop_q, rej_q, pend_q;
    logic push_n, pop_n, rej_n, pend_n;
    logic push_ev, pop_ev;
    logic can_push, can_pop;

    // Two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {bus.btn_pop, bus.btn_push};
            sync2 <= sync1;
        end
    end

    // Debounce: accept a new level only after DEB_CNT consecutive differing samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            deb   <= '0;
            deb_q <= '0;
        end else begin
            deb_q <= deb;
            for (int b = 0; b < int'(NB); b++) begin
                if (sync2[b] != deb[b]) begin
                    if (cnt[b] == CW'(DEB_CNT - 1)) begin
                        deb[b] <= ~deb[b];
                        cnt[b] <= '0;
                    end else begin
                        cnt[b] <= cnt[b] + CW'(1);
                    end
                end else begin
                    cnt[b] <= '0;
                end
            end
        end
    end

    // Press request on rising edge of the debounced level only
    assign req = deb & ~deb_q;

`ifdef AUTOREPEAT_EN
    logic [NB-1:0][CW-1:0] tmr;
    logic [NB-1:0]         rep;

    // Repeat request when the hold timer reaches the repeat point
    always_comb begin
        rep = '0;
        for (int b = 0; b < int'(NB); b++) begin
            rep[b] = deb[b] && (tmr[b] == CW'(REPEAT_DLY));
        end
    end

    // Hold timer: starts at the press, reloads so later repeats are REPEAT_PER apart
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr <= '0;
        end else begin
            for (int b = 0; b < int'(NB); b++) begin
                if (!deb[b]) begin
                    tmr[b] <= '0;
                end else if (req[b]) begin
                    tmr[b] <= CW'(1);
                end else if (rep[b]) begin
                    tmr[b] <= CW'(REPEAT_DLY - REPEAT_PER + 1);
                end else if (tmr[b] != '0) begin
                    tmr[b] <= tmr[b] + CW'(1);
                end
            end
        end
    end

    assign ev = req | rep;
`else
    assign ev = req;
`endif

    // Size gating; size is live feedback from the queue and is not registered
    assign can_push = 32'(bus.size) < MAXSIZE;
    assign can_pop  = bus.size != '0;

    // Arbitration: push wins a same-cycle conflict, the pop waits one cycle in pend
    always_comb begin
        push_n  = 1'b0;
        pop_n   = 1'b0;
        rej_n   = 1'b0;
        pend_n  = 1'b0;
        push_ev = ev[0];
        pop_ev  = ev[1] | pend_q;
        if (push_ev) begin
            if (can_push) push_n = 1'b1;
            else          rej_n  = 1'b1;
            pend_n = pop_ev;
        end else if (pop_ev) begin
            if (can_pop) pop_n = 1'b1;
            else         rej_n = 1'b1;
        end
    end

    // Registered strobes and pending-pop flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            push_q <= 1'b0;
            pop_q  <= 1'b0;
            rej_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            push_q <= push_n;
            pop_q  <= pop_n;
            rej_q  <= rej_n;
            pend_q <= pend_n;
        end
    end

    assign bus.push    = push_q;
    assign bus.pop     = pop_q;
    assign bus.rej     = rej_q;
    assign bus.btn_lvl = deb;

endmodule

// File: tb/tb_queue_btn_ctrl.sv
// Scoreboard bench for queue_btn_ctrl (DEB_CNT = 8, MAXSIZE = 16).
// Stimulus queues the expected strobe ({rej,pop,push}) and the cycle it must
// appear in; a negedge monitor pops and compares every strobe the DUT shows.
// A level driven at a negedge is first sampled at the next rising edge and the
// strobe is registered DEB_CNT+3 edges later counting that sampling edge, so the
// monitor sees it at (cycle at drive) + 11.
module tb_queue_btn_ctrl;

    localparam int unsigned DEB = 8;
    localparam int unsigned LAT = DEB + 3;
    localparam logic [2:0]  O_PUSH = 3'b001;
    localparam logic [2:0]  O_POP  = 3'b010;
    localparam logic [2:0]  O_REJ  = 3'b100;

    typedef struct packed {
        logic [2:0]  outs;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    queue_btn_ctrl_if bus();

    queue_btn_ctrl #(
        .DEB_CNT(DEB),
        .MAXSIZE(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Cycle counter, advanced on each rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    task automatic expect_at(input logic [2:0] o, input int unsigned c);
        exp_t e;
        e.outs = o;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every expected strobe must have been seen by now
    task automatic drained(input string name);
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: compare each observed strobe against the head of the scoreboard
    always @(negedge clk) begin
        logic [2:0] obs;
        exp_t       e;
        if (rst === 1'b1) begin
            obs = {bus.rej, bus.pop, bus.push};
            if (obs != 3'b000) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected strobe: got %b expected none (cycle %0d)", obs, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("strobe kind", 32'(obs), 32'(e.outs));
                    chk("strobe cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int unsigned t0;

        rst          = 1'b0;
        bus.btn_push = 1'b0;
        bus.btn_pop  = 1'b0;
        bus.size     = 5'd0;

        // Reset state, before any clock edge
        #1;
        chk("reset push", 32'(bus.push), 0);
        chk("reset pop", 32'(bus.pop), 0);
        chk("reset rej", 32'(bus.rej), 0);
        chk("reset btn_lvl", 32'(bus.btn_lvl), 0);
        wait_n(3);
        rst = 1'b1;
        wait_n(5);

        // 1: bounce shorter than DEB never accepted, final steady high gives one push
        bus.size = 5'd0;
        for (int i = 0; i < 10; i++) begin
            bus.btn_push = (i % 2 == 0);
            wait_n(3);
        end
        bus.btn_push = 1'b1;
        c0 = cyc;
        expect_at(O_PUSH, c0 + LAT);
        wait_n(20);
        chk("bounce btn_lvl", 32'(bus.btn_lvl), 32'h1);
        bus.btn_push = 1'b0;
        wait_n(20);
        chk("bounce release btn_lvl", 32'(bus.btn_lvl), 0);
        drained("bounce pending");

        // 2: full queue refuses push, pop still served
        bus.size = 5'd16;
        bus.btn_push = 1'b1;
        expect_at(O_REJ, cyc + LAT);
        wait_n(20);
        bus.btn_push = 1'b0;
        wait_n(20);
        drained("full push pending");
        bus.btn_pop = 1'b1;
        expect_at(O_POP, cyc + LAT);
        wait_n(20);
        chk("full pop btn_lvl", 32'(bus.btn_lvl), 32'h2);
        bus.btn_pop = 1'b0;
        wait_n(20);
        drained("full pop pending");

        // 3: empty queue refuses pop
        bus.size = 5'd0;
        bus.btn_pop = 1'b1;
        expect_at(O_REJ, cyc + LAT);
        wait_n(20);
        bus.btn_pop = 1'b0;
        wait_n(20);
        drained("empty pop pending");

        // 4: simultaneous press, push first then pop one cycle later
        bus.size = 5'd5;
        bus.btn_push = 1'b1;
        bus.btn_pop  = 1'b1;
        c0 = cyc;
        expect_at(O_PUSH, c0 + LAT);
        expect_at(O_POP, c0 + LAT + 1);
        wait_n(20);
        chk("simul btn_lvl", 32'(bus.btn_lvl), 32'h3);
        bus.btn_push = 1'b0;
        bus.btn_pop  = 1'b0;
        wait_n(20);
        drained("simul pending");

        // 5: reset while push strobe is high, held button is a fresh press afterwards
        bus.size = 5'd3;
        bus.btn_push = 1'b1;
        c0 = cyc;
        expect_at(O_PUSH, c0 + LAT);
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        #1;
        chk("pre-reset push", 32'(bus.push), 1);
        rst = 1'b0;
        #1;
        chk("async reset push", 32'(bus.push), 0);
        chk("async reset btn_lvl", 32'(bus.btn_lvl), 0);
        chk("async reset rej", 32'(bus.rej), 0);
        wait_n(3);
        rst = 1'b1;
        expect_at(O_PUSH, cyc + LAT);
        wait_n(20);
        bus.btn_push = 1'b0;
        wait_n(20);
        drained("reset pending");

        // 6: long hold; auto-repeat only when built with AUTOREPEAT_EN.
        // The raw release at t0+45 lets the debounced level fall at t0+55.
        bus.size = 5'd0;
        bus.btn_push = 1'b1;
        c0 = cyc;
        t0 = c0 + LAT;
        expect_at(O_PUSH, t0);
`ifdef AUTOREPEAT_EN
        expect_at(O_PUSH, t0 + 20);
        expect_at(O_PUSH, t0 + 30);
        expect_at(O_PUSH, t0 + 40);
        expect_at(O_PUSH, t0 + 50);
`endif
        wait_n(int'(LAT) + 45);
        bus.btn_push = 1'b0;
        wait_n(30);
        chk("hold release btn_lvl", 32'(bus.btn_lvl), 0);
        drained("hold pending");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
